// File: rtl/ser_rx_det.sv
// Serial receive stage: deserializes an enabled bit stream into bytes
// (first bit received becomes the MSB) and, on the same stream, detects
// a 4-bit PATTERN with overlapping matches and a saturating match count.
// i_clr is a synchronous clear that overrides i_en. The byte output
// keeps its last value across a clear.
module ser_rx_det #(
  parameter logic [3:0]  PATTERN = 4'b1011,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_data,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [7:0]       o_byte,
  output logic             o_byte_vld,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_cnt
);

  // Detector arming: no match is possible until four samples are in history.
  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } det_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: the count holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // Deserializer state
  logic [2:0]       bit_cnt_r;
  logic [6:0]       shift_r;
  // Detector state
  logic [3:0]       hist_r;
  logic [2:0]       fill_r;
  det_state_e       state_r;
  det_state_e       state_nxt_s;
  // Output registers
  logic [7:0]       byte_r;
  logic             byte_vld_r;
  logic             match_r;
  logic [CNT_W-1:0] match_cnt_r;

  // Combinational helpers
  logic             accept_s;
  logic             byte_done_s;
  logic [3:0]       hist_nxt_s;
  logic [2:0]       fill_nxt_s;
  logic             match_hit_s;

  // Sample qualification and the post-shift view of the detector for this edge.
  always_comb begin
    accept_s    = i_en & ~i_clr;
    hist_nxt_s  = {hist_r[2:0], i_data};
    byte_done_s = 1'b0;
    match_hit_s = 1'b0;
    if (fill_r == 3'd4) begin
      fill_nxt_s = 3'd4;
    end else begin
      fill_nxt_s = fill_r + 3'd1;
    end
    if (accept_s && (bit_cnt_r == 3'd7)) begin
      byte_done_s = 1'b1;
    end else begin
      byte_done_s = 1'b0;
    end
    // The current sample counts toward the fill, so the 4th sample can match.
    if (accept_s && (fill_nxt_s == 3'd4) && (hist_nxt_s == PATTERN)) begin
      match_hit_s = 1'b1;
    end else begin
      match_hit_s = 1'b0;
    end
  end

  // Detector FSM next state: arm on the 4th accepted sample, disarm only on clear.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (i_clr) begin
          state_nxt_s = ST_FILL;
        end else if (accept_s && (fill_nxt_s == 3'd4)) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_ARMED: begin
        if (i_clr) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      default: begin
        state_nxt_s = ST_FILL;
      end
    endcase
  end

  // Detector FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Deserializer shift register and bit counter; the counter wraps 7 -> 0 naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
    end else if (i_clr) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
    end else if (accept_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      shift_r   <= {shift_r[5:0], i_data};
    end else begin
      bit_cnt_r <= bit_cnt_r;
      shift_r   <= shift_r;
    end
  end

  // Detector history and saturating fill counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_r <= 4'd0;
      fill_r <= 3'd0;
    end else if (i_clr) begin
      hist_r <= 4'd0;
      fill_r <= 3'd0;
    end else if (accept_s) begin
      hist_r <= hist_nxt_s;
      fill_r <= fill_nxt_s;
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  // Byte output register and its one-cycle valid pulse; the byte survives a clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_r     <= 8'h00;
      byte_vld_r <= 1'b0;
    end else if (i_clr) begin
      byte_r     <= byte_r;
      byte_vld_r <= 1'b0;
    end else if (byte_done_s) begin
      byte_r     <= {shift_r, i_data};
      byte_vld_r <= 1'b1;
    end else begin
      byte_r     <= byte_r;
      byte_vld_r <= 1'b0;
    end
  end

  // Match pulse and saturating match counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      match_r     <= 1'b0;
      match_cnt_r <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      match_r     <= 1'b0;
      match_cnt_r <= {CNT_W{1'b0}};
    end else if (match_hit_s) begin
      match_r     <= 1'b1;
      match_cnt_r <= sat_inc(match_cnt_r);
    end else begin
      match_r     <= 1'b0;
      match_cnt_r <= match_cnt_r;
    end
  end

  assign o_byte      = byte_r;
  assign o_byte_vld  = byte_vld_r;
  assign o_match     = match_r;
  assign o_match_cnt = match_cnt_r;

endmodule

// File: tb/tb_ser_rx_det.sv
// Self-checking bench for ser_rx_det: a table of directed vectors with
// hand-computed expectations, hand-written reset/saturation sequences,
// and a randomized run checked against a queue-based reference model.
module tb_ser_rx_det;

  localparam logic [3:0] PAT = 4'b1011;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_data;
  logic       i_en;
  logic       i_clr;
  logic [7:0] o_byte;
  logic       o_byte_vld;
  logic       o_match;
  logic [7:0] o_match_cnt;

  ser_rx_det #(.PATTERN(PAT), .CNT_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_en        (i_en),
    .i_clr       (i_clr),
    .o_byte      (o_byte),
    .o_byte_vld  (o_byte_vld),
    .o_match     (o_match),
    .o_match_cnt (o_match_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accepted bits since reset/clear, kept as a plain list.
  bit         mq[$];
  int         m_nacc;
  logic [7:0] m_byte;
  logic       m_vld;
  logic       m_match;
  int         m_cnt;

  typedef struct {
    logic       en;
    logic       clr;
    logic       d;
    logic       vld;
    logic [7:0] bv;
    logic       match;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_nacc  = 0;
    m_byte  = 8'h00;
    m_vld   = 1'b0;
    m_match = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic en, input logic clr, input logic d);
    logic [3:0] w;
    m_vld   = 1'b0;
    m_match = 1'b0;
    if (clr) begin
      mq.delete();
      m_nacc = 0;
      m_cnt  = 0;
    end else if (en) begin
      mq.push_back(d);
      if (mq.size() > 8) void'(mq.pop_front());
      m_nacc++;
      if (m_nacc % 8 == 0) begin
        m_byte = 8'h00;
        foreach (mq[i]) m_byte = {m_byte[6:0], mq[i]};
        m_vld = 1'b1;
      end
      if (mq.size() >= 4) begin
        w = 4'b0000;
        for (int i = mq.size() - 4; i < mq.size(); i++) w = {w[2:0], mq[i]};
        if (w == PAT) begin
          m_match = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, sample at the following negedge.
  task automatic step(input logic en, input logic clr, input logic d);
    i_en   = en;
    i_clr  = clr;
    i_data = d;
    @(posedge i_clk);
    model_step(en, clr, d);
    @(negedge i_clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".vld"},   32'(o_byte_vld),  32'(m_vld));
    check({tag, ".byte"},  32'(o_byte),      32'(m_byte));
    check({tag, ".match"}, 32'(o_match),     32'(m_match));
    check({tag, ".cnt"},   32'(o_match_cnt), 32'(m_cnt));
  endtask

  task automatic add(input logic en, input logic clr, input logic d, input logic vld,
                     input logic [7:0] bv, input logic match, input logic [7:0] cnt);
    vec_t v;
    v.en = en; v.clr = clr; v.d = d; v.vld = vld; v.bv = bv; v.match = match; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] rep;
    logic [7:0] fresh;
    logic       en_r, clr_r, d_r;

    i_rst_n = 1'b0;
    i_en    = 1'b0;
    i_clr   = 1'b0;
    i_data  = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst.byte",  32'(o_byte),      32'h00);
    check("rst.vld",   32'(o_byte_vld),  32'h0);
    check("rst.match", 32'(o_match),     32'h0);
    check("rst.cnt",   32'(o_match_cnt), 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rel.vld",   32'(o_byte_vld), 32'h0);
    check("rel.match", 32'(o_match),    32'h0);

    // Byte A5: 1,0,1,0,0,1,0,1
    add(1,0,1, 0,8'h00,0,8'd0); add(1,0,0, 0,8'h00,0,8'd0);
    add(1,0,1, 0,8'h00,0,8'd0); add(1,0,0, 0,8'h00,0,8'd0);
    add(1,0,0, 0,8'h00,0,8'd0); add(1,0,1, 0,8'h00,0,8'd0);
    add(1,0,0, 0,8'h00,0,8'd0); add(1,0,1, 1,8'hA5,0,8'd0);
    add(1,0,0, 0,8'hA5,0,8'd0);
    // Clear, then overlapping matches on 1,0,1,1,0,1,1
    add(1,1,1, 0,8'hA5,0,8'd0);
    add(1,0,1, 0,8'hA5,0,8'd0); add(1,0,0, 0,8'hA5,0,8'd0);
    add(1,0,1, 0,8'hA5,0,8'd0); add(1,0,1, 0,8'hA5,1,8'd1);
    add(1,0,0, 0,8'hA5,0,8'd1); add(1,0,1, 0,8'hA5,0,8'd1);
    add(1,0,1, 0,8'hA5,1,8'd2);
    // Same stream with a 3-cycle enable gap after sample 2
    add(1,1,0, 0,8'hA5,0,8'd0);
    add(1,0,1, 0,8'hA5,0,8'd0); add(1,0,0, 0,8'hA5,0,8'd0);
    add(0,0,1, 0,8'hA5,0,8'd0); add(0,0,1, 0,8'hA5,0,8'd0);
    add(0,0,1, 0,8'hA5,0,8'd0);
    add(1,0,1, 0,8'hA5,0,8'd0); add(1,0,1, 0,8'hA5,1,8'd1);
    add(1,0,0, 0,8'hA5,0,8'd1); add(1,0,1, 0,8'hA5,0,8'd1);
    add(1,0,1, 0,8'hA5,1,8'd2);
    // Clear beats enable: 1,0,1 then clr+en with 1, then 1 -> still filling
    add(0,1,1, 0,8'hA5,0,8'd0);
    add(1,0,1, 0,8'hA5,0,8'd0); add(1,0,0, 0,8'hA5,0,8'd0);
    add(1,0,1, 0,8'hA5,0,8'd0); add(1,1,1, 0,8'hA5,0,8'd0);
    add(1,0,1, 0,8'hA5,0,8'd0); add(1,0,0, 0,8'hA5,0,8'd0);
    add(1,0,1, 0,8'hA5,0,8'd0); add(1,0,1, 0,8'hA5,1,8'd1);

    foreach (tbl[k]) begin
      step(tbl[k].en, tbl[k].clr, tbl[k].d);
      check($sformatf("tbl%0d.vld", k),   32'(o_byte_vld),  32'(tbl[k].vld));
      check($sformatf("tbl%0d.byte", k),  32'(o_byte),      32'(tbl[k].bv));
      check($sformatf("tbl%0d.match", k), 32'(o_match),     32'(tbl[k].match));
      check($sformatf("tbl%0d.cnt", k),   32'(o_match_cnt), 32'(tbl[k].cnt));
    end

    // Mid-byte asynchronous reset, then a fresh byte F0
    step(1,0,1); step(1,0,1); step(1,0,0); step(1,0,1); step(1,0,0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst.byte",  32'(o_byte),      32'h00);
    check("arst.vld",   32'(o_byte_vld),  32'h0);
    check("arst.match", 32'(o_match),     32'h0);
    check("arst.cnt",   32'(o_match_cnt), 32'h0);
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    fresh = 8'hF0;
    for (int k = 0; k < 8; k++) begin
      d_r = fresh[7-k];
      step(1'b1, 1'b0, d_r);
      check($sformatf("f0.vld%0d", k),   32'(o_byte_vld), 32'(k == 7));
      check($sformatf("f0.match%0d", k), 32'(o_match),    32'h0);
    end
    check("f0.byte", 32'(o_byte), 32'hF0);

    // 300 repetitions of the pattern: counter saturates, pulses continue
    rep = PAT;
    step(1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 300; r++) begin
      for (int j = 0; j < 4; j++) begin
        d_r = rep[3-j];
        step(1'b1, 1'b0, d_r);
        check($sformatf("sat.match r%0d j%0d", r, j), 32'(o_match), 32'(j == 3));
        if (j == 3)
          check($sformatf("sat.cnt r%0d", r), 32'(o_match_cnt), 32'((r + 1 > 255) ? 255 : r + 1));
      end
    end
    repeat (3) step(1'b0, 1'b0, 1'b1);
    check("sat.hold", 32'(o_match_cnt), 32'd255);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      en_r  = ($urandom_range(0, 3) != 0);
      clr_r = ($urandom_range(0, 39) == 0);
      d_r   = 1'($urandom_range(0, 1));
      step(en_r, clr_r, d_r);
      check_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ser_rx_det.md
SER_RX_DET -- requirements
Module: ser_rx_det

Interface
REQ-001 Parameter PATTERN, default 4'b1011: 4-bit sequence the detector matches, oldest bit in PATTERN[3].
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 Port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 Port i_data  input  1  serial data bit from the upstream stage (the upstream o_data stream).
REQ-006 Port i_en  input  1  sample enable; i_data is consumed only on an edge where i_en=1.
REQ-007 Port i_clr  input  1  synchronous clear of the counters and the history.
REQ-008 Port o_byte  output  8  last assembled byte, MSB = first bit received.
REQ-009 Port o_byte_vld  output  1  one-cycle pulse; o_byte was updated on the same edge.
REQ-010 Port o_match  output  1  one-cycle pulse; PATTERN was detected.
REQ-011 Port o_match_cnt  output  CNT_W  saturating count of detections.

Function
REQ-012 Sample accept: an edge with i_en=1 and i_clr=0 is an accepted sample; all other edges leave the shift register, bit counter, history and fill count unchanged.
REQ-013 Deserializer: 3-bit bit counter 0..7; each accepted sample shifts i_data into the LSB of a 7-bit shift register and increments the counter.
REQ-014 Byte completion: on the accepted sample taken when the counter is 7, the block loads o_byte <= {shift[6:0], i_data}, raises o_byte_vld for exactly that following cycle, and wraps the counter to 0.
REQ-015 o_byte holds its value until the next byte completes; o_byte_vld is 0 in every other cycle.
REQ-016 Detector history: each accepted sample shifts i_data into hist[0] of a 4-bit history register.
REQ-017 Fill counter: 3-bit, 0..4, increments per accepted sample and saturates at 4.
REQ-018 Detector states: FILL (fill<4, no match possible) and ARMED (fill==4).
REQ-019 FILL -> ARMED on the 4th accepted sample after reset or clear; ARMED persists until reset or i_clr.
REQ-020 Match: o_match=1 for the cycle after an accepted sample whose post-shift history equals PATTERN with fill==4 (counting this sample).
REQ-021 Overlap: detections overlap; no history flush after a match.
REQ-022 o_match_cnt increments by 1 on each match and saturates at 2^CNT_W-1; it never wraps.
REQ-023 Latency: one cycle from the accepting edge to o_byte_vld and to o_match; both may assert in the same cycle.
REQ-024 i_clr: has priority over i_en; on that edge the bit counter, shift register, history, fill (-> FILL) and o_match_cnt go to 0, and o_byte_vld and o_match go to 0; o_byte retains its value.
REQ-025 Back-to-back: with i_en held at 1, bytes complete every 8 cycles with no lost sample.

Reset
REQ-026 While i_rst_n=0, independent of the clock: o_byte=8'h00, o_byte_vld=0, o_match=0, o_match_cnt=0, bit counter=0, shift register=0, history=0, fill=0 (FILL).
REQ-027 Reset asserted mid-byte discards the partial byte; the first accepted sample after release is bit 7 of a new byte.
REQ-028 Reset release is not an accepted sample; it produces no pulse.

Verification
REQ-029 Reset, then i_en=1 with i_data 1,0,1,0,0,1,0,1 -> o_byte=8'hA5 and o_byte_vld pulses exactly once, one cycle after the 8th sample.
REQ-030 i_data 1,0,1,1,0,1,1 with i_en=1 -> o_match pulses after samples 4 and 7 (overlap) and o_match_cnt=2.
REQ-031 Same stream with i_en=0 for 3 cycles between samples 2 and 3 -> results identical to REQ-030 and no pulses during the gaps.
REQ-032 Feed 300 repetitions of 1,0,1,1 -> o_match_cnt stops at 255 and stays there; o_match still pulses on each detection.
REQ-033 Assert i_rst_n=0 after 5 samples, then send 8 fresh samples 1,1,1,1,0,0,0,0 -> o_byte=8'hF0 with no spurious o_byte_vld or o_match.
REQ-034 i_clr=1 together with i_en=1 after 3 samples of 1,0,1, then send 1 -> no match (back in FILL) and o_match_cnt=0.
